// File: rtl/xga_timing_gen.sv
// XGA (1024x768@70) raster timing generator gated by a synchronised PLL lock.
// Optional colour-bar generator is compiled in with `define XGA_TEST_PATTERN_EN.
module xga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 144,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        locked,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        line_start,
   output logic        frame_start,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        dbg_state
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

   // The state register doubles as the second synchroniser flop, so SCAN == run.
   logic   r_sync1;
   state_t r_state;
   state_t w_next;
   logic   w_run;
   logic [10:0] r_h;
   logic [9:0]  r_v;
   logic w_de, w_hs_n, w_vs_n, w_ls, w_fs;
   logic [23:0] w_rgb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_state <= S_IDLE;
      end else begin
         r_sync1 <= locked;
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (r_sync1)  w_next = S_SCAN;
         S_SCAN: if (!r_sync1) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_run = (r_state == S_SCAN);
   end

   assign dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (!w_run) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_h == H_LAST) begin
         r_h <= '0;
         r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
      end else begin
         r_h <= r_h + 11'd1;
      end
   end

   always_comb begin
      w_de   = w_run && (r_h < H_ACT) && (r_v < V_ACT);
      w_hs_n = !(w_run && (r_h >= HS_BEGIN) && (r_h < HS_END));
      w_vs_n = !(w_run && (r_v >= VS_BEGIN) && (r_v < VS_END));
      w_ls   = w_run && (r_h == 11'd0);
      w_fs   = w_ls && (r_v == 10'd0);
   end

`ifdef XGA_TEST_PATTERN_EN
   always_comb begin
      w_rgb = 24'h000000;
      if (w_de) begin
         case (r_h[9:7])
            3'd0: w_rgb = 24'hFFFFFF;
            3'd1: w_rgb = 24'hFFFF00;
            3'd2: w_rgb = 24'h00FFFF;
            3'd3: w_rgb = 24'h00FF00;
            3'd4: w_rgb = 24'hFF00FF;
            3'd5: w_rgb = 24'hFF0000;
            3'd6: w_rgb = 24'h0000FF;
            default: w_rgb = 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) {r, g, b} <= '0;
      else     {r, g, b} <= w_rgb;
   end
`else
   assign w_rgb = 24'h000000;
   assign {r, g, b} = w_rgb;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= w_hs_n;
         vsync       <= w_vs_n;
         de          <= w_de;
         x           <= w_run ? r_h : '0;
         y           <= w_run ? r_v : '0;
         line_start  <= w_ls;
         frame_start <= w_fs;
      end
   end
endmodule

// File: tb/tb_xga_timing_gen.sv
// Bench for xga_timing_gen: full horizontal timing, shortened vertical timing
// so whole frames fit in a short run. Scoreboard plus line/frame measurements.
module tb_xga_timing_gen;
   localparam int HA = 1024, HF = 24, HS = 136, HB = 144;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam logic [49:0] IDLE_VEC = {1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 24'd0};

   logic clk = 1'b0;
   logic rst, locked;
   logic hsync, vsync, de, line_start, frame_start, dbg_state;
   logic [10:0] x;
   logic [9:0]  y;
   logic [7:0]  r, g, b;

   int n_checks = 0;
   int n_fail   = 0;
   logic [49:0] exp_q[$];

   always #5 clk = ~clk;

   xga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start),
      .r(r), .g(g), .b(b), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: n cycles into a scan the raster position is pure arithmetic on n.
   function automatic logic [49:0] expect_at(input int n);
      int h, v;
      logic e_de, e_hs, e_vs;
      logic [23:0] e_rgb;
      logic [10:0] hx;
      h = n % HT;
      v = (n / HT) % VT;
      hx = 11'(h);
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      e_rgb = 24'h0;
`ifdef XGA_TEST_PATTERN_EN
      if (e_de) begin
         case (hx[9:7])
            3'd0: e_rgb = 24'hFFFFFF;
            3'd1: e_rgb = 24'hFFFF00;
            3'd2: e_rgb = 24'h00FFFF;
            3'd3: e_rgb = 24'h00FF00;
            3'd4: e_rgb = 24'hFF00FF;
            3'd5: e_rgb = 24'hFF0000;
            3'd6: e_rgb = 24'h0000FF;
            default: e_rgb = 24'h000000;
         endcase
      end
`endif
      return {e_hs, e_vs, e_de, hx, 10'(v), h == 0, (h == 0) && (v == 0), e_rgb};
   endfunction

   // Model: run at edge k is the lock level sampled two edges earlier.
   logic lh1 = 1'b0, lh2 = 1'b0;
   int   scan_n = 0;
   always @(posedge clk) begin
      if (rst) begin
         lh1 = 1'b0;
         lh2 = 1'b0;
         scan_n = 0;
         exp_q.push_back(IDLE_VEC);
      end else begin
         exp_q.push_back(lh2 ? expect_at(scan_n) : IDLE_VEC);
         scan_n = lh2 ? scan_n + 1 : 0;
         lh2 = lh1;
         lh1 = locked;
      end
   end

   int line_valid = 0, line_len, line_de, line_hs, hs_first, hs_last, line_y;
   int frame_valid = 0, frame_len, frame_de, frame_vs, vs_first_x, vs_first_y;

   always @(negedge clk) begin
      if (exp_q.size() > 0)
         check("outs", {hsync, vsync, de, x, y, line_start, frame_start, r, g, b}, exp_q.pop_front());
      if (x == 0 && !line_start) begin
         line_valid = 0;
         frame_valid = 0;
      end else begin
         if (line_start) begin
            if (line_valid != 0) begin
               check("line_len", line_len, HT);
               check("line_de", line_de, (line_y < VA) ? HA : 0);
               check("hs_len", line_hs, HS);
               check("hs_first_x", hs_first, 1048);
               check("hs_last_x", hs_last, 1183);
            end
            line_valid = 1; line_len = 0; line_de = 0; line_hs = 0;
            hs_first = -1; hs_last = -1; line_y = int'(y);
         end
         if (frame_start) begin
            if (frame_valid != 0) begin
               check("frame_len", frame_len, FRAME);
               check("frame_de", frame_de, HA * VA);
               check("vs_len", frame_vs, VS * HT);
               check("vs_first_y", vs_first_y, VA + VF);
               check("vs_first_x", vs_first_x, 0);
            end
            frame_valid = 1; frame_len = 0; frame_de = 0; frame_vs = 0;
            vs_first_x = -1; vs_first_y = -1;
         end
         line_len++;
         frame_len++;
         if (de) begin
            line_de++;
            frame_de++;
         end
         if (!hsync) begin
            if (line_hs == 0) hs_first = int'(x);
            hs_last = int'(x);
            line_hs++;
         end
         if (!vsync) begin
            if (frame_vs == 0) begin
               vs_first_x = int'(x);
               vs_first_y = int'(y);
            end
            frame_vs++;
         end
`ifdef XGA_TEST_PATTERN_EN
         if (y == 0) begin
            case (x)
               11'd0:    check("bar_x0",    {r, g, b}, 24'hFFFFFF);
               11'd128:  check("bar_x128",  {r, g, b}, 24'hFFFF00);
               11'd640:  check("bar_x640",  {r, g, b}, 24'hFF0000);
               11'd1023: check("bar_x1023", {r, g, b}, 24'h000000);
               11'd1100: check("bar_x1100", {r, g, b}, 24'h000000);
               default: ;
            endcase
         end
`endif
      end
   end

   task automatic wait_fs(input int budget, output int cyc);
      cyc = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (frame_start) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_hsync"}, hsync, 1'b1);
      check({tag, "_vsync"}, vsync, 1'b1);
      check({tag, "_de"}, de, 1'b0);
      check({tag, "_x"}, x, 11'd0);
      check({tag, "_y"}, y, 10'd0);
      check({tag, "_strobes"}, {line_start, frame_start}, 2'b00);
      check({tag, "_rgb"}, {r, g, b}, 24'd0);
   endtask

   initial begin
      int lat;
      int found;
      rst = 1'b1;
      locked = 1'b1;
      repeat (4) @(negedge clk);
      check_idle("reset");

      #1 locked = 1'b0;
      rst = 1'b0;
      repeat (3 + $urandom_range(0, 3)) @(negedge clk);
      #1 locked = 1'b1;
      wait_fs(10, lat);
      check("startup_lat", lat, 3);
      check("startup_de", de, 1'b1);
      wait_fs(FRAME + 10, lat);
      check("frame_period", lat, FRAME);

      found = 0;
      for (int i = 0; i < FRAME && found == 0; i++) begin
         @(negedge clk);
         if (x == 11'd500 && y == 10'd3) found = 1;
      end
      check("reach_500_3", found, 1);
      #1 locked = 1'b0;
      repeat (2) @(negedge clk);
      check("loss_still_run_x", x, 11'd502);
      @(negedge clk);
      check_idle("loss");

      repeat (5 + $urandom_range(0, 4)) @(negedge clk);
      #1 locked = 1'b1;
      wait_fs(10, lat);
      check("relock_lat", lat, 3);
      check("relock_xy", {x, y}, 21'd0);
      repeat (3 * HT + $urandom_range(0, 200)) @(negedge clk);

      #1 rst = 1'b1;
      #1 check_idle("async_rst");
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      wait_fs(10, lat);
      check("post_rst_lat", lat, 3);
      repeat (2 * HT) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
